shift_reg_univ_syn_ah: RTL

- Parametrised universal shift register and the next generation of the team's single-bit D flip-flop cells.
- Generalises the cell to WIDTH bits with mode-selected hold, shift, rotate, parallel load and clear, plus serial in/out.
- Adds a saturating fill counter, so the block also serves as a serial-to-parallel converter.
- Sits between serial link logic and parallel datapath registers.

---
 rtl/shift_reg_univ_syn_ah_pkg.sv | 16 +
 rtl/shift_reg_univ_syn_ah_fill_cnt.sv | 56 +++++
 rtl/shift_reg_univ_syn_ah.sv | 101 ++++++++++
 3 files changed

// File: rtl/shift_reg_univ_syn_ah_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit operation encodings driven on mode_in.
package shift_reg_univ_syn_ah_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
  // 3'b111 is reserved and decodes as HOLD.

endpackage

// File: rtl/shift_reg_univ_syn_ah_fill_cnt.sv
// shift_fill_cnt_syn_ah: saturating fill counter for the shift register.
// Counts valid bits shifted in, stopping at WIDTH.
// Ports:
//   clk          rising-edge clock
//   reset_ah_in  synchronous active-high reset (count -> 0)
//   inc_in       add one valid bit (ignored once saturated)
//   set_full_in  jump straight to WIDTH (parallel load)
//   clr_in       clear count to 0
//   cnt_out      current count, 0..WIDTH
//   full_out     high when cnt_out == WIDTH
module shift_fill_cnt_syn_ah #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_ah_in,
  input  logic                       inc_in,
  input  logic                       set_full_in,
  input  logic                       clr_in,
  output logic [$clog2(WIDTH+1)-1:0] cnt_out,
  output logic                       full_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full;

  assign full = (cnt_q == CNT_MAX);

  // Clear beats load beats increment; the caller only asserts one at a time,
  // but a fixed priority keeps the behaviour defined regardless.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (set_full_in) begin
      cnt_d = CNT_MAX;
    end else if (inc_in && !full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out  = cnt_q;
  assign full_out = full;

endmodule

// File: rtl/shift_reg_univ_syn_ah.sv
// shift_reg_univ_syn_ah: parametrised universal shift register with
// hold / shift / rotate / parallel load / clear and a saturating fill count.
// Ports:
//   clk           rising-edge clock
//   reset_ah_in   synchronous active-high reset (q -> RESET_VAL, count -> 0)
//   en_in         clock enable; low freezes register and count
//   mode_in       operation select (see package encodings)
//   d_in          parallel load data
//   ser_r_in      serial bit entering at LSB on shift left
//   ser_l_in      serial bit entering at MSB on shift right
//   q_out         register contents
//   ser_l_out     q_out MSB
//   ser_r_out     q_out LSB
//   fill_cnt_out  valid bits shifted in, saturating at WIDTH
//   full_out      fill_cnt_out == WIDTH
module shift_reg_univ_syn_ah
  import shift_reg_univ_syn_ah_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset_ah_in,
  input  logic              en_in,
  input  logic [2:0]        mode_in,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              ser_r_in,
  input  logic              ser_l_in,
  output logic [WIDTH-1:0]  q_out,
  output logic              ser_l_out,
  output logic              ser_r_out,
  output logic [CNT_W-1:0]  fill_cnt_out,
  output logic              full_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             cnt_inc;
  logic             cnt_set_full;
  logic             cnt_clr;

  // Mode mux. Enable is folded in here so a disabled cycle issues no
  // counter commands and leaves q_d == q_q.
  always_comb begin
    q_d          = q_q;
    cnt_inc      = 1'b0;
    cnt_set_full = 1'b0;
    cnt_clr      = 1'b0;
    if (en_in) begin
      case (mode_in)
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], ser_r_in};
          cnt_inc = 1'b1;
        end
        MODE_SHR: begin
          q_d     = {ser_l_in, q_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        // Rotates only reorder existing bits, so the count is untouched.
        MODE_ROL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR: q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_LOAD: begin
          q_d          = d_in;
          cnt_set_full = 1'b1;
        end
        // Clear goes to zero, not RESET_VAL.
        MODE_CLR: begin
          q_d     = '0;
          cnt_clr = 1'b1;
        end
        default: q_d = q_q;  // HOLD and reserved 3'b111
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  shift_fill_cnt_syn_ah #(
    .WIDTH (WIDTH)
  ) u_fill_cnt (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .inc_in      (cnt_inc),
    .set_full_in (cnt_set_full),
    .clr_in      (cnt_clr),
    .cnt_out     (fill_cnt_out),
    .full_out    (full_out)
  );

  assign q_out     = q_q;
  assign ser_l_out = q_q[WIDTH-1];
  assign ser_r_out = q_q[0];

endmodule
